read_response_reorder_buffer: RTL and testbench
===============================================

// Module: read_response_reorder_buffer
// PURPOSE
//  Parametrised successor to read_response_buffer. Holds DDR read bursts that return out of order.
//  Data may arrive out of order across bank schedulers and out of order within a burst.
//  Bursts are returned to the host port in the order their requests were issued.
//  Sits between the PHY read-capture path (fill side) and the host read channel (rsp side).
// PARAMETERS
//  DATA_W    64  width of one read beat
//  DEPTH      8  outstanding burst slots; power of 2, >=2
//  BURST_LEN  4  beats per burst; power of 2, >=1
//  ID_W       4  host transaction ID width
//  Derived: TAG_W=$clog2(DEPTH), BEAT_W=max(1,$clog2(BURST_LEN))
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous active-high reset
//  alloc_valid    in   1       scheduler issues a read; reserve a slot
//  alloc_id       in   ID_W    host ID stored with the slot
//  alloc_ready    out  1       slot available (count<DEPTH)
//  alloc_tag      out  TAG_W   slot index granted; equals head pointer
//  fill_valid     in   1       one beat of read data returned
//  fill_tag       in   TAG_W   slot the beat belongs to
//  fill_beat      in   BEAT_W  beat index within the burst
//  fill_data      in   DATA_W  beat payload
//  fill_err       in   1       ECC/PHY error flag for this beat
//  rsp_valid      out  1       host beat valid
//  rsp_ready      in   1       host accepts beat
//  rsp_id         out  ID_W    ID of the draining slot
//  rsp_data       out  DATA_W  beat payload, beat order 0..BURST_LEN-1
//  rsp_err        out  1       stored fill_err of this beat
//  rsp_last       out  1       final beat of the burst
//  occupancy      out  TAG_W+1 allocated, not-yet-drained slots
//  protocol_err   out  1       sticky: illegal fill seen
// BEHAVIOUR
//  Reset (async assert, sync release): head=tail=0, count=0, all slots FREE, beat masks=0.
//   Outputs on reset: rsp_valid=0, rsp_last=0, occupancy=0, protocol_err=0, alloc_ready=1.
//   Data storage is not cleared. Reset mid-burst drops all in-flight slots silently.
//  Slot states: FREE -> PENDING (alloc) -> COMPLETE (beat mask all 1s) -> FREE (last beat drained).
//  Alloc: on alloc_valid&&alloc_ready, slot[head] becomes PENDING with id=alloc_id and mask=0.
//   head increments mod DEPTH. alloc_tag is valid in the same cycle as the handshake.
//  Fill: legal only if slot[fill_tag] is PENDING and mask[fill_beat]==0.
//   A legal fill writes data and err, and sets the mask bit.
//   An illegal fill (FREE/COMPLETE slot, or duplicate beat) is dropped and sets protocol_err until rst.
//  A slot becomes COMPLETE on the cycle after its final mask bit is written.
//   rsp_valid may rise no earlier than that same cycle, i.e. 1 cycle after the last fill_valid.
//  Drain: rsp_valid=1 iff slot[tail] is COMPLETE.
//   rsp_* are read combinationally from {tail, drain_beat} and stay stable while rsp_valid&&!rsp_ready.
//   Each handshake increments drain_beat. rsp_last=(drain_beat==BURST_LEN-1).
//   On the last handshake: slot->FREE, tail++ mod DEPTH, drain_beat=0.
//   A completed burst streams back-to-back at 1 beat/cycle.
//  Younger complete slots wait behind an incomplete tail (no bypass).
//  Full/empty: count tracks alloc minus retire.
//   alloc_ready is computed from the registered count only. There is no same-cycle bypass of a retiring slot.
//   Simultaneous alloc and retire leaves count unchanged. occupancy=count.
//  Pointer wrap: pointers are TAG_W bits with natural wrap. Full vs empty is told apart by count.
//  Same-cycle alloc and fill to the newly allocated tag: the fill is illegal (slot still FREE that cycle).
//  Fill to the tail slot in the same cycle its drain begins: impossible, since the slot is COMPLETE only after all fills.
// STRUCTURE
//  ddr_ctrl_pkg: rrb_slot_state_e {RRB_FREE, RRB_PENDING, RRB_COMPLETE}, and the TAG_W/BEAT_W helper functions.
//  Sub-module rrb_data_ram holds DEPTH*BURST_LEN x (DATA_W+1) words.
//   It has one synchronous write port (fill) and one asynchronous read port (drain).
//  Top level holds slot state, ID, beat masks, pointers, count and drain_beat.
// TESTING
//  1. Reset mid-operation: 3 allocs, 2 fills, then assert rst.
//     -> occupancy=0, rsp_valid=0, alloc_tag=0, alloc_ready=1 on the following cycle.
//  2. In-order single burst: alloc id=5; fill beats 0..3 with data 0xA0..0xA3.
//     -> rsp_valid 1 cycle after beat3; 4 beats, id=5, rsp_last on 0xA3.
//  3. Out-of-order across slots: alloc ids 1,2; complete tag1 fully, then tag0.
//     -> no rsp until tag0 completes; then id1 burst, then id2 burst, back-to-back.
//  4. Out-of-order within a burst: fill beats 3,1,0,2, with fill_err on beat1.
//     -> rsp_data in beat order 0..3; rsp_err=1 only on beat1.
//  5. Full plus backpressure: DEPTH allocs -> alloc_ready=0, occupancy=DEPTH.
//     Fill tag0 and hold rsp_ready=0 for 5 cycles -> rsp_data stable.
//     Release rsp_ready; alloc_ready returns the cycle after rsp_last handshakes.
//     Next alloc_tag=0 (wrap).
//  6. Illegal fills: fill to a FREE tag, then a duplicate beat to a PENDING tag.
//     -> protocol_err=1 and sticky; storage and masks unchanged; subsequent legal traffic unaffected.

Source files
------------

// File: rtl/ddr_ctrl_pkg.sv
// Shared types and width helpers for the DDR read-response reorder buffer.
package ddr_ctrl_pkg;

    // Lifecycle of one outstanding burst slot.
    typedef enum logic [1:0] {
        RRB_FREE     = 2'd0,
        RRB_PENDING  = 2'd1,
        RRB_COMPLETE = 2'd2
    } rrb_slot_state_e;

    // Slot tag width; a single-slot buffer still gets a 1-bit tag.
    function automatic int rrb_tag_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Beat index width; single-beat bursts still get a 1-bit index.
    function automatic int rrb_beat_w(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/rrb_data_ram.sv
// Beat storage for the reorder buffer: one synchronous write port fed by the
// fill side, one asynchronous read port feeding the host side.
module rrb_data_ram #(
    parameter int WORD_W = 65,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int WORDS = 1 << ADDR_W;

    // Contents are deliberately never cleared; validity lives in the slot masks.
    logic [WORD_W-1:0] mem_reg [WORDS];

    // Capture each accepted fill beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Drain side sees the addressed beat in the same cycle.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/read_response_reorder_buffer.sv
// Reorder buffer for DDR read bursts: slots are reserved in request order,
// beats land in any order, and whole bursts drain to the host in request order.
module read_response_reorder_buffer
    import ddr_ctrl_pkg::*;
#(
    parameter int  DATA_W    = 64,
    parameter int  DEPTH     = 8,
    parameter int  BURST_LEN = 4,
    parameter int  ID_W      = 4,
    localparam int TAG_W     = rrb_tag_w(DEPTH),
    localparam int BEAT_W    = rrb_beat_w(BURST_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [ID_W-1:0]   alloc_id,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              fill_valid,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [BEAT_W-1:0] fill_beat,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              fill_err,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ID_W-1:0]   rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic [TAG_W:0]    occupancy,
    output logic              protocol_err
);

    localparam int LOG_BL = $clog2(BURST_LEN);
    localparam int ADDR_W = TAG_W + LOG_BL;
    localparam int WORD_W = DATA_W + 1;

    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [TAG_W:0]       FULL_COUNT = (TAG_W + 1)'(DEPTH);
    localparam logic [BURST_LEN-1:0] MASK_FULL  = '1;

    // Per-slot bookkeeping.
    rrb_slot_state_e      slot_state_reg [DEPTH];
    logic [ID_W-1:0]      slot_id_reg    [DEPTH];
    logic [BURST_LEN-1:0] slot_mask_reg  [DEPTH];

    // Ring pointers, occupancy and drain progress.
    logic [TAG_W-1:0]  head_reg, head_next;
    logic [TAG_W-1:0]  tail_reg, tail_next;
    logic [TAG_W:0]    count_reg, count_next;
    logic [BEAT_W-1:0] drain_beat_reg, drain_beat_next;
    logic              protocol_err_reg, protocol_err_next;

    logic                 alloc_fire;
    logic                 fill_beat_ok;
    logic [BURST_LEN-1:0] fill_onehot;
    logic                 fill_legal;
    logic                 rsp_fire;
    logic                 retire;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_word;

    // Full is decided purely from the registered count: a slot retiring this
    // cycle cannot be re-granted until the next one.
    assign alloc_ready = (count_reg < FULL_COUNT);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = head_reg;

    // Beat index range guard only matters when a burst is a single beat.
    if (BURST_LEN == 1) begin : gen_beat_chk
        assign fill_beat_ok = (fill_beat == '0);
    end else begin : gen_beat_nochk
        assign fill_beat_ok = 1'b1;
    end

    assign fill_onehot = BURST_LEN'(1) << fill_beat;

    // A fill lands only in a PENDING slot whose beat has not yet arrived; a
    // slot granted this very cycle is still FREE and therefore rejects it.
    assign fill_legal = fill_valid && fill_beat_ok
                        && (slot_state_reg[fill_tag] == RRB_PENDING)
                        && ((slot_mask_reg[fill_tag] & fill_onehot) == '0);

    // Strict in-order drain: only the tail slot may present data.
    assign rsp_valid = (slot_state_reg[tail_reg] == RRB_COMPLETE);
    assign rsp_last  = rsp_valid && (drain_beat_reg == LAST_BEAT);
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign retire    = rsp_fire && rsp_last;
    assign rsp_id    = slot_id_reg[tail_reg];
    assign rsp_data  = rd_word[DATA_W-1:0];
    assign rsp_err   = rd_word[DATA_W];

    assign occupancy    = count_reg;
    assign protocol_err = protocol_err_reg;

    // Storage is addressed as {slot, beat}.
    if (BURST_LEN == 1) begin : gen_addr_flat
        assign wr_addr = fill_tag;
        assign rd_addr = tail_reg;
    end else begin : gen_addr_beat
        assign wr_addr = {fill_tag, fill_beat};
        assign rd_addr = {tail_reg, drain_beat_reg};
    end

    rrb_data_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_data_ram (
        .clk     (clk),
        .wr_en   (fill_legal),
        .wr_addr (wr_addr),
        .wr_data ({fill_err, fill_data}),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    // Slot lifecycle: one register set per slot, each reacting to its own tag.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_slot
        localparam logic [TAG_W-1:0] SLOT_TAG = TAG_W'(gi);

        logic                 alloc_hit;
        logic                 retire_hit;
        logic                 fill_hit;
        logic [BURST_LEN-1:0] mask_next;

        assign alloc_hit  = alloc_fire && (head_reg == SLOT_TAG);
        assign retire_hit = retire && (tail_reg == SLOT_TAG);
        assign fill_hit   = fill_legal && (fill_tag == SLOT_TAG);
        assign mask_next  = slot_mask_reg[gi] | fill_onehot;

        // Allocation opens the slot, the final fill completes it, the last
        // drained beat frees it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot_state_reg[gi] <= RRB_FREE;
                slot_mask_reg[gi]  <= '0;
                slot_id_reg[gi]    <= '0;
            end else if (alloc_hit) begin
                slot_state_reg[gi] <= RRB_PENDING;
                slot_mask_reg[gi]  <= '0;
                slot_id_reg[gi]    <= alloc_id;
            end else if (retire_hit) begin
                slot_state_reg[gi] <= RRB_FREE;
            end else if (fill_hit) begin
                slot_mask_reg[gi] <= mask_next;
                if (mask_next == MASK_FULL) begin
                    slot_state_reg[gi] <= RRB_COMPLETE;
                end
            end
        end
    end

    // Next-state for pointers, count, drain beat and the sticky error flag.
    always_comb begin
        head_next         = head_reg;
        tail_next         = tail_reg;
        count_next        = count_reg;
        drain_beat_next   = drain_beat_reg;
        protocol_err_next = protocol_err_reg;

        if (alloc_fire) begin
            head_next = head_reg + 1'b1;
        end

        if (rsp_fire) begin
            if (rsp_last) begin
                drain_beat_next = '0;
                tail_next       = tail_reg + 1'b1;
            end else begin
                drain_beat_next = drain_beat_reg + 1'b1;
            end
        end

        case ({alloc_fire, retire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        if (fill_valid && !fill_legal) begin
            protocol_err_next = 1'b1;
        end
    end

    // Register the ring control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            drain_beat_reg   <= '0;
            protocol_err_reg <= 1'b0;
        end else begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
            drain_beat_reg   <= drain_beat_next;
            protocol_err_reg <= protocol_err_next;
        end
    end

endmodule

// File: tb/tb_read_response_reorder_buffer.sv
// Directed bench for read_response_reorder_buffer (DEPTH=8, BURST_LEN=4).
module tb_read_response_reorder_buffer;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 8;
    localparam int BURST_LEN = 4;
    localparam int ID_W      = 4;
    localparam int TAG_W     = 3;
    localparam int BEAT_W    = 2;

    logic              clk;
    logic              rst;
    logic              alloc_valid;
    logic [ID_W-1:0]   alloc_id;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              fill_valid;
    logic [TAG_W-1:0]  fill_tag;
    logic [BEAT_W-1:0] fill_beat;
    logic [DATA_W-1:0] fill_data;
    logic              fill_err;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              rsp_last;
    logic [TAG_W:0]    occupancy;
    logic              protocol_err;

    int total = 0;
    int bad   = 0;

    read_response_reorder_buffer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .BURST_LEN (BURST_LEN),
        .ID_W      (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_id     (alloc_id),
        .alloc_ready  (alloc_ready),
        .alloc_tag    (alloc_tag),
        .fill_valid   (fill_valid),
        .fill_tag     (fill_tag),
        .fill_beat    (fill_beat),
        .fill_data    (fill_data),
        .fill_err     (fill_err),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_last     (rsp_last),
        .occupancy    (occupancy),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [ID_W-1:0] id, input logic [TAG_W-1:0] exp_tag);
        alloc_valid = 1'b1;
        alloc_id    = id;
        #1;
        check("alloc_ready", alloc_ready, 1);
        check("alloc_tag", alloc_tag, exp_tag);
        $display("alloc id=%0d tag=%0d", id, alloc_tag);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [TAG_W-1:0] tag, input logic [BEAT_W-1:0] beat,
                           input logic [DATA_W-1:0] data, input logic err);
        fill_valid = 1'b1;
        fill_tag   = tag;
        fill_beat  = beat;
        fill_data  = data;
        fill_err   = err;
        $display("fill tag=%0d beat=%0d data=0x%0h err=%0d", tag, beat, data, err);
        tick();
        fill_valid = 1'b0;
        fill_err   = 1'b0;
    endtask

    // Drains one whole burst without idle cycles; the burst must already be complete.
    task automatic drain_burst(input logic [ID_W-1:0] id, input logic [63:0] base,
                               input logic [3:0] err_mask);
        logic [63:0] exp_data;
        for (int b = 0; b < BURST_LEN; b++) begin
            rsp_ready = 1'b1;
            exp_data  = base + 64'(b);
            #1;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, id);
            check("rsp_data", rsp_data, exp_data);
            check("rsp_err", rsp_err, err_mask[b]);
            check("rsp_last", rsp_last, (b == BURST_LEN - 1) ? 1 : 0);
            $display("rsp id=%0d data=0x%0h err=%0d last=%0d", rsp_id, rsp_data, rsp_err, rsp_last);
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("async_rst_occupancy", occupancy, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_id    = '0;
        fill_valid  = 1'b0;
        fill_tag    = '0;
        fill_beat   = '0;
        fill_data   = '0;
        fill_err    = 1'b0;
        rsp_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_occupancy", occupancy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        rst = 1'b0;
        tick();

        // 1: reset mid-operation
        do_alloc(4'd1, 3'd0);
        do_alloc(4'd2, 3'd1);
        do_alloc(4'd3, 3'd2);
        do_fill(3'd0, 2'd0, 64'h11, 1'b0);
        do_fill(3'd0, 2'd1, 64'h12, 1'b0);
        check("t1_occupancy_pre", occupancy, 3);
        pulse_reset();
        check("t1_occupancy", occupancy, 0);
        check("t1_rsp_valid", rsp_valid, 0);
        check("t1_alloc_tag", alloc_tag, 0);
        check("t1_alloc_ready", alloc_ready, 1);

        // 2: in-order single burst
        do_alloc(4'd5, 3'd0);
        do_fill(3'd0, 2'd0, 64'hA0, 1'b0);
        do_fill(3'd0, 2'd1, 64'hA1, 1'b0);
        do_fill(3'd0, 2'd2, 64'hA2, 1'b0);
        check("t2_rsp_valid_early", rsp_valid, 0);
        do_fill(3'd0, 2'd3, 64'hA3, 1'b0);
        drain_burst(4'd5, 64'hA0, 4'b0000);
        check("t2_rsp_valid_after", rsp_valid, 0);
        check("t2_occupancy", occupancy, 0);

        // 3: out of order across slots
        do_alloc(4'd1, 3'd1);
        do_alloc(4'd2, 3'd2);
        for (int b = 0; b < BURST_LEN; b++) do_fill(3'd2, 2'(b), 64'hB0 + 64'(b), 1'b0);
        check("t3_blocked_0", rsp_valid, 0);
        tick();
        check("t3_blocked_1", rsp_valid, 0);
        for (int b = 0; b < BURST_LEN - 1; b++) do_fill(3'd1, 2'(b), 64'hC0 + 64'(b), 1'b0);
        check("t3_blocked_2", rsp_valid, 0);
        do_fill(3'd1, 2'd3, 64'hC3, 1'b0);
        drain_burst(4'd1, 64'hC0, 4'b0000);
        drain_burst(4'd2, 64'hB0, 4'b0000);
        check("t3_occupancy", occupancy, 0);

        // 4: out of order within a burst, error on beat 1
        do_alloc(4'd7, 3'd3);
        do_fill(3'd3, 2'd3, 64'hD3, 1'b0);
        do_fill(3'd3, 2'd1, 64'hD1, 1'b1);
        do_fill(3'd3, 2'd0, 64'hD0, 1'b0);
        check("t4_rsp_valid_early", rsp_valid, 0);
        do_fill(3'd3, 2'd2, 64'hD2, 1'b0);
        drain_burst(4'd7, 64'hD0, 4'b0010);
        check("t4_protocol_err", protocol_err, 0);

        // 5: full plus backpressure
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) do_alloc(4'(i), 3'(i));
        check("t5_alloc_ready_full", alloc_ready, 0);
        check("t5_occupancy_full", occupancy, 8);
        alloc_valid = 1'b1;
        alloc_id    = 4'hF;
        tick();
        alloc_valid = 1'b0;
        check("t5_occupancy_refused", occupancy, 8);
        for (int b = 0; b < BURST_LEN; b++) do_fill(3'd0, 2'(b), 64'hE0 + 64'(b), 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_data", rsp_data, 64'hE0);
            check("t5_hold_last", rsp_last, 0);
            $display("hold cycle=%0d data=0x%0h", c, rsp_data);
            tick();
        end
        for (int b = 0; b < BURST_LEN; b++) begin
            rsp_ready = 1'b1;
            #1;
            check("t5_rsp_data", rsp_data, 64'hE0 + 64'(b));
            check("t5_rsp_last", rsp_last, (b == BURST_LEN - 1) ? 1 : 0);
            check("t5_no_bypass", alloc_ready, 0);
            $display("rsp id=%0d data=0x%0h last=%0d", rsp_id, rsp_data, rsp_last);
            tick();
        end
        rsp_ready = 1'b0;
        check("t5_alloc_ready_back", alloc_ready, 1);
        check("t5_occupancy_after", occupancy, 7);
        do_alloc(4'd9, 3'd0);
        check("t5_occupancy_refill", occupancy, 8);

        // 6: illegal fills
        pulse_reset();
        check("t6_protocol_err_clear", protocol_err, 0);
        do_fill(3'd3, 2'd0, 64'h33, 1'b0);
        check("t6_free_fill", protocol_err, 1);
        // allocate tag0 while filling it in the same cycle: the fill must be dropped
        alloc_valid = 1'b1;
        alloc_id    = 4'hA;
        fill_valid  = 1'b1;
        fill_tag    = 3'd0;
        fill_beat   = 2'd1;
        fill_data   = 64'hDEAD;
        #1;
        check("t6_same_cycle_tag", alloc_tag, 0);
        $display("alloc id=%0d tag=%0d with same-cycle fill", alloc_id, alloc_tag);
        tick();
        alloc_valid = 1'b0;
        fill_valid  = 1'b0;
        do_fill(3'd0, 2'd0, 64'hF0, 1'b0);
        do_fill(3'd0, 2'd0, 64'hBAD, 1'b1);
        check("t6_sticky", protocol_err, 1);
        do_fill(3'd0, 2'd1, 64'hF1, 1'b0);
        do_fill(3'd0, 2'd2, 64'hF2, 1'b0);
        check("t6_rsp_valid_early", rsp_valid, 0);
        do_fill(3'd0, 2'd3, 64'hF3, 1'b0);
        drain_burst(4'hA, 64'hF0, 4'b0000);
        check("t6_sticky_end", protocol_err, 1);
        check("t6_occupancy", occupancy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
